image_filter_axi_lite_regs: RTL and testbench
=============================================

// Module: image_filter_axi_lite_regs
// PURPOSE
//  AXI4-Lite slave register file for the image_filter IP; it sits directly downstream of the AXI4-Lite master.
//  It decodes the single-beat write and read transfers and holds four read/write configuration registers.
//  It also exposes status and frame-count registers, emits a one-cycle start pulse and raises a level interrupt.
//  Filter datapath consumes cfg_* outputs and reports back through filt_busy/filt_frame_done.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  5   byte address width; 8 word slots (0x00-0x1C)
// PORTS
//  S_AXI_ACLK     in   1   clock, all logic on rising edge
//  S_AXI_ARESETN  in   1   asynchronous active-low reset
//  S_AXI_AWADDR   in   5   write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1: write address handshake
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte lane enables
//  S_AXI_WVALID   in   1   / S_AXI_WREADY  out 1: write data handshake
//  S_AXI_BRESP    out  2   always 2'b00 (OKAY)
//  S_AXI_BVALID   out  1   / S_AXI_BREADY  in  1: write response handshake
//  S_AXI_ARADDR   in   5   read address; S_AXI_ARPROT in 3, ignored
//  S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1: read address handshake
//  S_AXI_RDATA    out  32  read data; S_AXI_RRESP out 2, always 2'b00
//  S_AXI_RVALID   out  1   / S_AXI_RREADY  in  1: read data handshake
//  cfg_ctrl, cfg_thresh, cfg_kernel, cfg_scratch  out 32 each: REG0..REG3 contents
//  start_pulse    out  1   1-cycle pulse on a committed REG0 write with WSTRB[0]=1 and WDATA[0]=1
//  filt_busy      in   1   datapath busy level
//  filt_frame_done in  1   1-cycle pulse at end of each frame
//  irq            out  1   done_sticky & REG0[2]
// BEHAVIOUR
//  Reset: all READY/VALID outputs 0; RDATA, RESP, REG0-3, done_sticky, frame_cnt 0; start_pulse 0; irq 0.
//  Map: 0x00 REG0 CTRL RW; 0x04 REG1 RW; 0x08 REG2 RW; 0x0C REG3 RW; these four read back exactly what was written.
//   0x10 STATUS: bit0 = filt_busy; bit1 = done_sticky, write-1-to-clear; other bits read 0.
//   0x14 FRAME_CNT: read-only. 0x18/0x1C: reads return 0, writes ignored. Address bits[1:0] ignored. All transfers respond OKAY.
//  Write: AW and W are accepted independently in any order; each is latched into a holding reg.
//   AWREADY is high while no AW is held and BVALID=0; WREADY follows the same rule with W.
//   Both may handshake in the same cycle.
//   When both are held, the write commits in the next cycle; BVALID rises in the same cycle, holding regs clear.
//   BVALID stays high until BREADY; no new AW or W is accepted while BVALID=1.
//   Best case, from simultaneous AW and W handshake to BVALID: 1 cycle.
//  Byte strobes: lane n of REG0-3 is updated only if WSTRB[n]=1. STATUS W1C uses lane 0 only.
//  start_pulse is high in the commit cycle only; REG0[0] itself stays stored, not self-clearing.
//  Read: ARREADY = ~RVALID. On AR handshake, RDATA is registered from current values and RVALID=1 next cycle.
//   RDATA and RVALID are held until RREADY. Read latency: 1 cycle.
//  Read and write commit to the same address in the same cycle: the read returns the pre-write value.
//  done_sticky: set by filt_frame_done, cleared by W1C. Simultaneous set and clear: set wins.
//  frame_cnt: +1 per filt_frame_done, 32-bit, wraps 0xFFFFFFFF->0; a read in the increment cycle returns the old value.
//  irq is registered: it follows done_sticky & REG0[2] with 1 cycle latency.
//  Reset asserted mid-transaction: all state clears immediately and in-flight transfers are dropped.
//   No response is issued after reset releases.
// TESTING
//  1 Write 0x0101FFFF/0xABCD0001/0xDEAD0011/0xBEEF0011 to 0x00/04/08/0C, read each back -> exact match, RESP=OKAY.
//  2 W 2 cycles before AW to 0x04 = 0x12345678 -> BVALID 1 cycle after AW handshake; readback 0x12345678.
//   Then hold BREADY low 5 cycles -> BVALID and AWREADY/WREADY stay put.
//  3 REG1=0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> read 0xFF00FF00.
//  4 Write REG0=0x5 -> start_pulse high exactly 1 cycle, REG0 reads 0x5.
//   Then pulse filt_frame_done 3x -> FRAME_CNT=3, STATUS bit1=1, irq=1.
//   Then write STATUS 0x2 -> bit1=0, irq=0.
//  5 W1C STATUS in the same cycle as filt_frame_done -> bit1 stays 1.
//   Preload via 0xFFFFFFFF pulses (force), one more pulse -> FRAME_CNT=0.
//  6 Read 0x1C -> 0x0, OKAY. Assert ARESETN low while BVALID=1 -> all outputs 0 asynchronously; no BVALID after release.

Source files
------------

// File: rtl/image_filter_axi_lite_regs.sv
// AXI4-Lite slave register file for the image_filter IP.
// Four RW config registers, STATUS (busy + W1C done flag), read-only FRAME_CNT,
// a one-cycle start pulse on REG0[0] writes and a registered level interrupt.
module image_filter_axi_lite_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_thresh,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_kernel,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_scratch,
    output logic                            start_pulse,
    input  logic                            filt_busy,
    input  logic                            filt_frame_done,
    output logic                            irq
);

    localparam int NumLanes = int'(C_S_AXI_DATA_WIDTH / 8);

    // Held low through reset and for the first cycle after it, so no READY is
    // offered while the block is still coming out of reset.
    logic                            r_init;

    logic                            r_aw_held;
    logic [2:0]                      r_aw_idx;
    logic                            r_w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_w_data;
    logic [NumLanes-1:0]             r_w_strb;
    logic                            r_bvalid;

    logic                            r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;

    logic [C_S_AXI_DATA_WIDTH-1:0]   r_cfg [4];
    logic                            r_done_sticky;
    logic [31:0]                     r_frame_cnt;
    logic                            r_start;
    logic                            r_irq;

    logic                            w_awready;
    logic                            w_wready;
    logic                            w_arready;
    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_ar_hs;
    logic                            w_commit;
    logic                            w_status_clr;
    logic [2:0]                      w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
    logic                            w_unused;

    assign w_awready = r_init & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_init & ~r_w_held & ~r_bvalid;
    assign w_arready = r_init & ~r_rvalid;

    assign w_aw_hs   = S_AXI_AWVALID & w_awready;
    assign w_w_hs    = S_AXI_WVALID & w_wready;
    assign w_ar_hs   = S_AXI_ARVALID & w_arready;

    // Holding regs can only both be full while BVALID is low.
    assign w_commit  = r_aw_held & r_w_held;

    assign w_status_clr = w_commit & (r_aw_idx == 3'd4) & r_w_strb[0] & r_w_data[1];

    assign w_rd_idx  = S_AXI_ARADDR[4:2];

    // Protection bits and byte offsets within a word carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Read mux over the current register values (pre-write on a same-cycle commit).
    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            3'd0: w_rd_data = r_cfg[0];
            3'd1: w_rd_data = r_cfg[1];
            3'd2: w_rd_data = r_cfg[2];
            3'd3: w_rd_data = r_cfg[3];
            3'd4: begin
                w_rd_data[0] = filt_busy;
                w_rd_data[1] = r_done_sticky;
            end
            3'd5: w_rd_data = r_frame_cnt;
            default: w_rd_data = '0;
        endcase
    end

    // Write channel: independent AW/W capture, commit when both held, B response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_init    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[4:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: capture data on AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // Byte-lane-masked update of REG0..REG3 on commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (w_commit && !r_aw_idx[2]) begin
            for (int n = 0; n < NumLanes; n++) begin
                if (r_w_strb[n]) begin
                    r_cfg[r_aw_idx[1:0]][8*n +: 8] <= r_w_data[8*n +: 8];
                end
            end
        end
    end

    // Start pulse, done flag (set beats clear), frame counter and interrupt.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_start       <= 1'b0;
            r_done_sticky <= 1'b0;
            r_frame_cnt   <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_start <= w_commit & (r_aw_idx == 3'd0) & r_w_strb[0] & r_w_data[0];
            if (filt_frame_done) begin
                r_done_sticky <= 1'b1;
            end else if (w_status_clr) begin
                r_done_sticky <= 1'b0;
            end
            if (filt_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            r_irq <= r_done_sticky & r_cfg[0][2];
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign cfg_ctrl      = r_cfg[0];
    assign cfg_thresh    = r_cfg[1];
    assign cfg_kernel    = r_cfg[2];
    assign cfg_scratch   = r_cfg[3];
    assign start_pulse   = r_start;
    assign irq           = r_irq;

endmodule

// File: tb/tb_image_filter_axi_lite_regs.sv
// Directed bench for image_filter_axi_lite_regs; read expectations go through a scoreboard queue.
module tb_image_filter_axi_lite_regs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] cfg_ctrl, cfg_thresh, cfg_kernel, cfg_scratch;
    logic        start_pulse;
    logic        filt_busy = 1'b0;
    logic        filt_frame_done = 1'b0;
    logic        irq;

    int          n_checks = 0;
    int          n_fail = 0;
    int          sp_cnt = 0;
    logic [31:0] sb_q[$];

    image_filter_axi_lite_regs dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rstn),
        .S_AXI_AWADDR    (awaddr),
        .S_AXI_AWPROT    (awprot),
        .S_AXI_AWVALID   (awvalid),
        .S_AXI_AWREADY   (awready),
        .S_AXI_WDATA     (wdata),
        .S_AXI_WSTRB     (wstrb),
        .S_AXI_WVALID    (wvalid),
        .S_AXI_WREADY    (wready),
        .S_AXI_BRESP     (bresp),
        .S_AXI_BVALID    (bvalid),
        .S_AXI_BREADY    (bready),
        .S_AXI_ARADDR    (araddr),
        .S_AXI_ARPROT    (arprot),
        .S_AXI_ARVALID   (arvalid),
        .S_AXI_ARREADY   (arready),
        .S_AXI_RDATA     (rdata),
        .S_AXI_RRESP     (rresp),
        .S_AXI_RVALID    (rvalid),
        .S_AXI_RREADY    (rready),
        .cfg_ctrl        (cfg_ctrl),
        .cfg_thresh      (cfg_thresh),
        .cfg_kernel      (cfg_kernel),
        .cfg_scratch     (cfg_scratch),
        .start_pulse     (start_pulse),
        .filt_busy       (filt_busy),
        .filt_frame_done (filt_frame_done),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_pulse) sp_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok = 0;
        bit w_ok = 0;
        bit aw_rdy;
        bit w_rdy;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_rdy = awready;
            w_rdy  = wready;
            tick();
            n++;
            if (awvalid && aw_rdy) begin aw_ok = 1; awvalid = 1'b0; end
            if (wvalid && w_rdy) begin w_ok = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chkb("wr_aw_accepted", aw_ok, 1'b1);
        chkb("wr_w_accepted", w_ok, 1'b1);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chkb("wr_bvalid", bvalid, 1'b1);
        chk("wr_bresp", {30'b0, bresp}, 32'h0);
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        bit ok = 0;
        bit rdy;
        int n = 0;
        sb_q.push_back(exp);
        araddr = a; arvalid = 1'b1;
        while (!ok && n < 20) begin
            rdy = arready;
            tick();
            n++;
            if (rdy) begin ok = 1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        chkb({tag, "_ar_accepted"}, ok, 1'b1);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chkb({tag, "_rvalid"}, rvalid, 1'b1);
        e = sb_q.pop_front();
        chk(tag, rdata, e);
        chk({tag, "_rresp"}, {30'b0, rresp}, 32'h0);
        tick();
        rready = 1'b0;
    endtask

    task automatic frame_pulse();
        filt_frame_done = 1'b1;
        tick();
        filt_frame_done = 1'b0;
        tick();
    endtask

    initial begin
        int sp0;
        logic [31:0] exp_fc;
        exp_fc = 0;

        // Reset state
        tick(); tick();
        chk("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
        chk("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cfg", cfg_ctrl | cfg_thresh | cfg_kernel | cfg_scratch, 32'h0);
        chk("rst_pulse_irq", {30'b0, start_pulse, irq}, 32'h0);
        rstn = 1'b1;
        tick(); tick();
        chk("idle_ready", {29'b0, awready, wready, arready}, 32'h7);

        // 1: basic write/readback
        axi_write(5'h00, 32'h0101FFFF, 4'hF);
        axi_write(5'h04, 32'hABCD0001, 4'hF);
        axi_write(5'h08, 32'hDEAD0011, 4'hF);
        axi_write(5'h0C, 32'hBEEF0011, 4'hF);
        axi_read(5'h00, 32'h0101FFFF, "t1_reg0");
        axi_read(5'h04, 32'hABCD0001, "t1_reg1");
        axi_read(5'h08, 32'hDEAD0011, "t1_reg2");
        axi_read(5'h0C, 32'hBEEF0011, "t1_reg3");
        axi_read(5'h05, 32'hABCD0001, "t1_lowbits_ignored");
        chk("t1_cfg_kernel", cfg_kernel, 32'hDEAD0011);

        // 2: W two cycles ahead of AW, then BREADY held low
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        chkb("t2_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        tick(); tick();
        chkb("t2_no_bvalid_w_only", bvalid, 1'b0);
        awaddr = 5'h04; awvalid = 1'b1;
        chkb("t2_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        chkb("t2_bvalid_at_hs", bvalid, 1'b0);
        tick();
        chkb("t2_bvalid_lat1", bvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", {29'b0, bvalid, awready, wready}, 32'h4);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chkb("t2_bvalid_cleared", bvalid, 1'b0);
        axi_read(5'h04, 32'h12345678, "t2_reg1");

        // 3: byte strobes
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF);
        axi_write(5'h04, 32'h00000000, 4'b0101);
        axi_read(5'h04, 32'hFF00FF00, "t3_strobe");

        // 4: start pulse, frame counting, irq, W1C
        sp0 = sp_cnt;
        axi_write(5'h00, 32'h00000005, 4'hF);
        tick();
        chk("t4_start_pulse_cycles", sp_cnt - sp0, 32'd1);
        axi_read(5'h00, 32'h00000005, "t4_reg0");
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            exp_fc++;
        end
        chkb("t4_irq_set", irq, 1'b1);
        axi_read(5'h14, exp_fc, "t4_frame_cnt");
        axi_read(5'h10, 32'h00000002, "t4_status_done");
        axi_write(5'h10, 32'h00000002, 4'h1);
        tick();
        chkb("t4_irq_cleared", irq, 1'b0);
        axi_read(5'h10, 32'h00000000, "t4_status_cleared");
        filt_busy = 1'b1;
        axi_read(5'h10, 32'h00000001, "t4_status_busy");
        filt_busy = 1'b0;

        // 5: W1C colliding with frame_done, set wins
        awaddr = 5'h10; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        chk("t5_ready", {30'b0, awready, wready}, 32'h3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        filt_frame_done = 1'b1;
        tick();
        filt_frame_done = 1'b0;
        exp_fc++;
        chkb("t5_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(5'h10, 32'h00000002, "t5_set_wins");
        axi_read(5'h14, exp_fc, "t5_frame_cnt");
        // Counter wrap
        force dut.r_frame_cnt = 32'hFFFFFFFF;
        tick();
        release dut.r_frame_cnt;
        axi_read(5'h14, 32'hFFFFFFFF, "t5_preload");
        frame_pulse();
        axi_read(5'h14, 32'h00000000, "t5_wrap");

        // 6: unmapped reads/writes, reset mid-transaction
        axi_read(5'h1C, 32'h0, "t6_unmapped_1c");
        axi_write(5'h18, 32'hCAFEF00D, 4'hF);
        axi_read(5'h18, 32'h0, "t6_unmapped_18");
        awaddr = 5'h04; wdata = 32'h000000AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chkb("t6_bvalid_pending", bvalid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_ready", {29'b0, awready, wready, arready}, 32'h0);
        chk("t6_rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
        chk("t6_rst_cfg", cfg_ctrl | cfg_thresh | cfg_kernel | cfg_scratch, 32'h0);
        chk("t6_rst_pulse_irq", {30'b0, start_pulse, irq}, 32'h0);
        tick(); tick();
        rstn = 1'b1;
        bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb("t6_no_bvalid_after_rst", bvalid, 1'b0);
        end
        bready = 1'b0;
        axi_read(5'h04, 32'h0, "t6_reg1_after_rst");
        axi_read(5'h14, 32'h0, "t6_frame_cnt_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
